// File: rtl/spi_ram_cmd_arbiter.sv
// Round-robin arbiter that serialises two requesters' read/write transactions into RAM command words
// and routes read data back to the issuing requester. Optional macro ADDR_SKIP_EN elides repeated address words.
`timescale 1ns/1ps
module spi_ram_cmd_arbiter #(
  parameter int ADDR_SIZE   = 8,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic                 i_req0_we,
  input  logic [ADDR_SIZE-1:0] i_req0_addr,
  input  logic [7:0]           i_req0_wdata,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic                 i_req1_we,
  input  logic [ADDR_SIZE-1:0] i_req1_addr,
  input  logic [7:0]           i_req1_wdata,
  output logic                 o_rsp0_valid,
  output logic [7:0]           o_rsp0_rdata,
  output logic                 o_rsp0_err,
  output logic                 o_rsp1_valid,
  output logic [7:0]           o_rsp1_rdata,
  output logic                 o_rsp1_err,
  output logic [9:0]           o_ram_din,
  output logic                 o_ram_rx_valid,
  input  logic [7:0]           i_ram_dout,
  input  logic                 i_ram_tx_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR, S_R_CMD, S_WAIT_RSP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rr;
  logic                  r_owner;
  logic [7:0]            r_wdata;
  logic [7:0]            r_tmo;
  logic [9:0]            r_ram_din;
  logic                  r_ram_rxv;
  logic                  r_rsp0_valid, r_rsp1_valid;
  logic [7:0]            r_rsp0_rdata, r_rsp1_rdata;
  logic                  r_rsp0_err, r_rsp1_err;

  logic                  w_grant0, w_grant1, w_acc, w_sel;
  logic                  w_sel_we;
  logic [ADDR_SIZE-1:0]  w_sel_addr;
  logic [7:0]            w_sel_wdata;
  logic                  w_wr_hit, w_rd_hit;
  logic [9:0]            w_din_nxt;
  logic                  w_rxv_nxt;
  logic [7:0]            w_tmo_nxt;
  logic                  w_rsp_fire, w_rsp_err;
  logic [7:0]            w_rsp_data;

  // r_rr holds the last winner; on a tie the other requester is granted.
  assign w_grant0    = i_req0_valid & (~i_req1_valid | r_rr);
  assign w_grant1    = i_req1_valid & (~i_req0_valid | ~r_rr);
  assign w_acc       = (r_state == S_IDLE) & (w_grant0 | w_grant1);
  assign w_sel       = w_grant1;
  assign w_sel_we    = w_sel ? i_req1_we    : i_req0_we;
  assign w_sel_addr  = w_sel ? i_req1_addr  : i_req0_addr;
  assign w_sel_wdata = w_sel ? i_req1_wdata : i_req0_wdata;

  assign o_req0_ready = (r_state == S_IDLE) & w_grant0;
  assign o_req1_ready = (r_state == S_IDLE) & w_grant1;

`ifdef ADDR_SKIP_EN
  logic [ADDR_SIZE-1:0] r_last_wr_addr, r_last_rd_addr;
  logic                 r_last_wr_vld,  r_last_rd_vld;

  assign w_wr_hit = r_last_wr_vld & (r_last_wr_addr == w_sel_addr);
  assign w_rd_hit = r_last_rd_vld & (r_last_rd_addr == w_sel_addr);

  // Tags mirror the RAM's internal write/read address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr_addr <= '0;
      r_last_rd_addr <= '0;
      r_last_wr_vld  <= 1'b0;
      r_last_rd_vld  <= 1'b0;
    end else if (w_rxv_nxt && (r_state == S_IDLE)) begin
      if (w_din_nxt[9:8] == 2'b00) begin
        r_last_wr_addr <= w_sel_addr;
        r_last_wr_vld  <= 1'b1;
      end
      if (w_din_nxt[9:8] == 2'b10) begin
        r_last_rd_addr <= w_sel_addr;
        r_last_rd_vld  <= 1'b1;
      end
    end
  end
`else
  assign w_wr_hit = 1'b0;
  assign w_rd_hit = 1'b0;
`endif

  // Next-state logic computes the word the RAM sees in the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = 10'h000;
    w_rxv_nxt   = 1'b0;
    w_tmo_nxt   = r_tmo;
    w_rsp_fire  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_rxv_nxt = 1'b1;
          if (w_sel_we) begin
            if (w_wr_hit) begin
              w_state_nxt = S_W_DATA;
              w_din_nxt   = {2'b01, w_sel_wdata};
            end else begin
              w_state_nxt = S_W_ADDR;
              w_din_nxt   = {2'b00, 8'(w_sel_addr)};
            end
          end else begin
            if (w_rd_hit) begin
              w_state_nxt = S_R_CMD;
              w_din_nxt   = {2'b11, 8'h00};
            end else begin
              w_state_nxt = S_R_ADDR;
              w_din_nxt   = {2'b10, 8'(w_sel_addr)};
            end
          end
        end
      end
      S_W_ADDR: begin
        w_state_nxt = S_W_DATA;
        w_rxv_nxt   = 1'b1;
        w_din_nxt   = {2'b01, r_wdata};
      end
      S_W_DATA: w_state_nxt = S_IDLE;
      S_R_ADDR: begin
        w_state_nxt = S_R_CMD;
        w_rxv_nxt   = 1'b1;
        w_din_nxt   = {2'b11, 8'h00};
      end
      S_R_CMD: begin
        w_state_nxt = S_WAIT_RSP;
        w_tmo_nxt   = 8'h00;
      end
      S_WAIT_RSP: begin
        if (i_ram_tx_valid) begin
          w_rsp_fire  = 1'b1;
          w_rsp_data  = i_ram_dout;
          w_state_nxt = S_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_rsp_fire  = 1'b1;
          w_rsp_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt   = r_tmo + 8'h01;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b1;
      r_owner      <= 1'b0;
      r_wdata      <= 8'h00;
      r_tmo        <= 8'h00;
      r_ram_din    <= 10'h000;
      r_ram_rxv    <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= 8'h00;
      r_rsp1_rdata <= 8'h00;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo        <= w_tmo_nxt;
      r_ram_din    <= w_din_nxt;
      r_ram_rxv    <= w_rxv_nxt;
      r_rsp0_valid <= w_rsp_fire & ~r_owner;
      r_rsp1_valid <= w_rsp_fire & r_owner;
      if (w_acc) begin
        r_rr    <= w_sel;
        r_owner <= w_sel;
        r_wdata <= w_sel_wdata;
      end
      if (w_rsp_fire && !r_owner) begin
        r_rsp0_rdata <= w_rsp_data;
        r_rsp0_err   <= w_rsp_err;
      end
      if (w_rsp_fire && r_owner) begin
        r_rsp1_rdata <= w_rsp_data;
        r_rsp1_err   <= w_rsp_err;
      end
    end
  end

  assign o_ram_din      = r_ram_din;
  assign o_ram_rx_valid = r_ram_rxv;
  assign o_rsp0_valid   = r_rsp0_valid;
  assign o_rsp0_rdata   = r_rsp0_rdata;
  assign o_rsp0_err     = r_rsp0_err;
  assign o_rsp1_valid   = r_rsp1_valid;
  assign o_rsp1_rdata   = r_rsp1_rdata;
  assign o_rsp1_err     = r_rsp1_err;

endmodule

// File: tb/tb_spi_ram_cmd_arbiter.sv
// Scoreboard bench for spi_ram_cmd_arbiter: stimulus pushes expected RAM words and responses, monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_ram_cmd_arbiter;

  localparam int TMO = 15;
`ifdef ADDR_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00, req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit kill_tx = 1'b0;

  typedef struct { logic [9:0] din; int cyc; } word_t;
  typedef struct { int port; logic [7:0] data; logic err; int cyc; } rsp_t;
  word_t exp_w[$];
  rsp_t  exp_r[$];

  logic [7:0] mem [256];
  logic [7:0] ram_wa = 8'h00, ram_ra = 8'h00;

  spi_ram_cmd_arbiter #(.ADDR_SIZE(8), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_we(req0_we),
    .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_we(req1_we),
    .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata), .o_rsp0_err(rsp0_err),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata), .o_rsp1_err(rsp1_err),
    .o_ram_din(ram_din), .o_ram_rx_valid(ram_rx_valid),
    .i_ram_dout(ram_dout), .i_ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-cycle RAM.
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wa <= ram_din[7:0];
        2'b01: mem[ram_wa] <= ram_din[7:0];
        2'b10: ram_ra <= ram_din[7:0];
        default: if (!kill_tx) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= mem[ram_ra];
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_exclusive", 32'(req0_ready & req1_ready), 0);
      if (ram_rx_valid) begin
        if (exp_w.size() == 0) chk("ram_word_unexpected", exp_w.size(), 1);
        else begin
          word_t w;
          w = exp_w.pop_front();
          chk("ram_din", 32'(ram_din), 32'(w.din));
          chk("ram_din_cycle", cyc, w.cyc);
        end
      end else begin
        chk("ram_din_idle_zero", 32'(ram_din), 0);
      end
      if (rsp0_valid || rsp1_valid) begin
        chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 0);
        if (exp_r.size() == 0) chk("rsp_unexpected", exp_r.size(), 1);
        else begin
          rsp_t r;
          r = exp_r.pop_front();
          chk("rsp_port", rsp1_valid ? 1 : 0, r.port);
          chk("rsp_rdata", 32'(rsp1_valid ? rsp1_rdata : rsp0_rdata), 32'(r.data));
          chk("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(r.err));
          chk("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic set_req(input int port, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Expected words/responses for a transaction accepted in cycle k.
  task automatic push_exp(input int port, input bit we, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rd, input bit tmo, input bit skip, input int k);
    word_t w;
    rsp_t  r;
    if (we) begin
      if (!skip) begin
        w.din = {2'b00, a}; w.cyc = k + 1; exp_w.push_back(w);
        w.din = {2'b01, d}; w.cyc = k + 2; exp_w.push_back(w);
      end else begin
        w.din = {2'b01, d}; w.cyc = k + 1; exp_w.push_back(w);
      end
    end else begin
      if (!skip) begin
        w.din = {2'b10, a};   w.cyc = k + 1; exp_w.push_back(w);
        w.din = 10'h300;      w.cyc = k + 2; exp_w.push_back(w);
      end else begin
        w.din = 10'h300;      w.cyc = k + 1; exp_w.push_back(w);
      end
      r.port = port;
      r.data = tmo ? 8'h00 : rd;
      r.err  = tmo;
      r.cyc  = k + (skip ? 2 : 3) + (tmo ? TMO : 1);
      exp_r.push_back(r);
    end
  endtask

  task automatic wait_acc(input int port, output int k);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (port == 0 ? req0_ready : req1_ready) got = 1'b1;
      else n++;
    end
    chk("accept_within_budget", 32'(got), 1);
    k = cyc;
  endtask

  task automatic do_req(input int port, input bit we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input bit tmo, input bit skip, output int k);
    set_req(port, 1'b1, we, a, d);
    wait_acc(port, k);
    push_exp(port, we, a, d, rd, tmo, skip, k);
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, k2;
    int g[4];
    int exp_g[4];
    int n, i0, i1, guard;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_g = '{0, 1, 0, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ram_rx_valid", 32'(ram_rx_valid), 0);
    chk("reset_ram_din", 32'(ram_din), 0);
    chk("reset_rsp_valids", 32'({rsp0_valid, rsp1_valid}), 0);
    chk("reset_rsp_data", 32'({rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err}), 0);
    @(posedge clk); #1;

    // T1: write 0x12 <- 0xA5
    do_req(0, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 1'b0, k);
    drain(6);
    // T2: requester 1 reads it back
    do_req(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 1'b0, k);
    drain(8);
    chk("t2_rsp1_rdata_held", 32'(rsp1_rdata), 32'h00A5);
    chk("t2_rsp0_rdata_untouched", 32'(rsp0_rdata), 0);

    // T3: both requesters held valid; req0 writes, req1 reads what was written
    for (int i = 0; i < 4; i++) g[i] = -1;
    n = 0; i0 = 0; i1 = 0; guard = 0;
    set_req(0, 1'b1, 1'b1, 8'h20, 8'h11);
    set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    while (n < 4 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (req0_ready) begin
        g[n] = 0; n++;
        push_exp(0, 1'b1, 8'(8'h20 + i0), 8'(8'h11 * (i0 + 1)), 8'h00, 1'b0, 1'b0, cyc);
        i0++;
        @(posedge clk); #1;
        if (i0 < 2) set_req(0, 1'b1, 1'b1, 8'(8'h20 + i0), 8'(8'h11 * (i0 + 1)));
        else        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      end else if (req1_ready) begin
        g[n] = 1; n++;
        push_exp(1, 1'b0, 8'(8'h20 + i1), 8'h00, 8'(8'h11 * (i1 + 1)), 1'b0, 1'b0, cyc);
        i1++;
        @(posedge clk); #1;
        if (i1 < 2) set_req(1, 1'b1, 1'b0, 8'(8'h20 + i1), 8'h00);
        else        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    chk("t3_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", g[i], exp_g[i]);
    drain(8);

    // T4: RAM never answers -> timeout; FSM is back in IDLE on the response cycle
    kill_tx = 1'b1;
    do_req(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b1, 1'b0, k);
    set_req(1, 1'b1, 1'b1, 8'h31, 8'h77);
    wait_acc(1, k2);
    chk("t4_idle_after_timeout_cycle", k2, k + 3 + TMO);
    push_exp(1, 1'b1, 8'h31, 8'h77, 8'h00, 1'b0, 1'b0, k2);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    kill_tx = 1'b0;
    drain(6);

    // T5: reset during R_CMD drops the transaction
    set_req(1, 1'b1, 1'b0, 8'h12, 8'h00);
    wait_acc(1, k);
    push_exp(1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, k);
    void'(exp_w.pop_back());  // read aborted after its address word; patch below
    exp_w[exp_w.size() - 1].din = {2'b10, 8'h12};
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ram_rx_valid", 32'(ram_rx_valid), 0);
    chk("t5_rst_ram_din", 32'(ram_din), 0);
    chk("t5_rst_rsp_valids", 32'({rsp0_valid, rsp1_valid}), 0);
    chk("t5_rst_rsp1_rdata", 32'(rsp1_rdata), 0);
    chk("t5_rst_rsp0_err", 32'(rsp0_err), 0);
    drain(2);
    rst_n = 1'b1;
    drain(25);
    do_req(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 1'b0, k);
    drain(8);

    // T6: repeated write/read addresses
    do_req(0, 1'b1, 8'h40, 8'h01, 8'h00, 1'b0, 1'b0, k);
    drain(4);
    do_req(0, 1'b1, 8'h40, 8'h02, 8'h00, 1'b0, SKIP, k);
    drain(4);
    do_req(1, 1'b0, 8'h40, 8'h00, 8'h02, 1'b0, 1'b0, k);
    drain(8);
    do_req(0, 1'b0, 8'h40, 8'h00, 8'h02, 1'b0, SKIP, k);
    drain(30);

    chk("exp_words_drained", exp_w.size(), 0);
    chk("exp_rsps_drained", exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
